// File: rtl/sreg_file_mp.sv
// sreg_file_mp -- parametrised scalar register file.
//
// DEPTH = 2**ADDR_W registers of WIDTH bits (WIDTH a multiple of 8).
// Two registered read ports (1-cycle latency), one byte-lane-masked write
// port with write-first bypass into both read ports, and a per-register
// busy scoreboard for outstanding loads.
//
// Ports:
//   Clk                 system clock, rising edge
//   Rst                 asynchronous active-high reset
//   RdEnA/RdAddrA       port A read request / address
//   DataOutA/ValidA     port A registered data / fresh-and-not-busy flag
//   RdEnB/RdAddrB       port B read request / address
//   DataOutB/ValidB     port B registered data / fresh-and-not-busy flag
//   WrEn/WrAddr         write request / address
//   WrByteEn            byte-lane enables, lane i = DataIn[8i+7:8i]
//   DataIn              write data
//   BusySet/BusyAddr    mark register BusyAddr pending
//   BusyVec             scoreboard, bit n = register n busy
//
// Optional feature: define SREG_ZERO_REG_EN to hardwire register 0 to zero
// (writes and BusySet to address 0 ignored, reads of 0 return 0, Valid=1).
module sreg_file_mp #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      RdEnA,
  input  logic [ADDR_W-1:0]         RdAddrA,
  output logic [WIDTH-1:0]          DataOutA,
  output logic                      ValidA,
  input  logic                      RdEnB,
  input  logic [ADDR_W-1:0]         RdAddrB,
  output logic [WIDTH-1:0]          DataOutB,
  output logic                      ValidB,
  input  logic                      WrEn,
  input  logic [ADDR_W-1:0]         WrAddr,
  input  logic [WIDTH/8-1:0]        WrByteEn,
  input  logic [WIDTH-1:0]          DataIn,
  input  logic                      BusySet,
  input  logic [ADDR_W-1:0]         BusyAddr,
  output logic [(1<<ADDR_W)-1:0]    BusyVec
);

  localparam int LANES = WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_W;

`ifdef SREG_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  // Replace enabled byte lanes of old_v with those of new_v.
  function automatic logic [WIDTH-1:0] lane_merge(
    input logic [WIDTH-1:0] old_v,
    input logic [WIDTH-1:0] new_v,
    input logic [LANES-1:0] be
  );
    logic [WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // ---- stage p0: decode, write merge, bypass, effective busy ----
  logic             wr_go_p0;
  logic             set_go_p0;
  logic [WIDTH-1:0] wr_data_p0;
  logic [WIDTH-1:0] rd_a_p0;
  logic [WIDTH-1:0] rd_b_p0;
  logic             vld_a_p0;
  logic             vld_b_p0;

  // A write to the hardwired zero register changes nothing, but a plain
  // WrEn still clears that register's busy bit (which is never set anyway).
  assign wr_go_p0   = WrEn && !(ZERO_REG && (WrAddr == '0));
  assign set_go_p0  = BusySet && !(ZERO_REG && (BusyAddr == '0));
  assign wr_data_p0 = lane_merge(regs[WrAddr], DataIn, WrByteEn);

  always_comb begin
    rd_a_p0 = regs[RdAddrA];
    if (wr_go_p0 && (WrAddr == RdAddrA)) rd_a_p0 = wr_data_p0;
    if (ZERO_REG && (RdAddrA == '0))      rd_a_p0 = '0;
    rd_b_p0 = regs[RdAddrB];
    if (wr_go_p0 && (WrAddr == RdAddrB)) rd_b_p0 = wr_data_p0;
    if (ZERO_REG && (RdAddrB == '0))      rd_b_p0 = '0;
  end

  // Busy seen by a read: this edge's write-clear applies, this edge's set
  // does not.
  assign vld_a_p0 = !(busy[RdAddrA] && !(WrEn && (WrAddr == RdAddrA)));
  assign vld_b_p0 = !(busy[RdAddrB] && !(WrEn && (WrAddr == RdAddrB)));

  // ---- stage p1: architectural state and registered outputs ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_go_p0) begin
      regs[WrAddr] <= wr_data_p0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      busy <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) begin
        if (set_go_p0 && (BusyAddr == ADDR_W'(n)))
          busy[n] <= 1'b1;
        else if (WrEn && (WrAddr == ADDR_W'(n)))
          busy[n] <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      DataOutA <= '0;
      ValidA   <= 1'b0;
      DataOutB <= '0;
      ValidB   <= 1'b0;
    end else begin
      ValidA <= RdEnA && vld_a_p0;
      ValidB <= RdEnB && vld_b_p0;
      if (RdEnA) DataOutA <= rd_a_p0;
      if (RdEnB) DataOutB <= rd_b_p0;
    end
  end

  assign BusyVec = busy;

endmodule
